// File: rtl/mod_mult_barrett_32b.sv
// Pipelined 32-bit modular multiplier: oData = (iData0 * iData1) mod iMod.
// Barrett reduction with k = 32; the caller supplies iU = floor(2^64 / iMod).
// Fixed 10-register latency, one operand pair per enabled clock. The modulus and
// constant travel with their data, so every cycle may use a different modulus.
module mod_mult_barrett_32b (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic        iEn,
  input  logic        iClr,
  input  logic [63:0] iU,
  input  logic [31:0] iData0,
  input  logic [31:0] iData1,
  input  logic [31:0] iMod,
  output logic [31:0] oData
);

  // All pipeline state in one packed record so reset and clear are a single '0.
  typedef struct packed {
    // S1: input capture
    logic [31:0] s1A;
    logic [31:0] s1B;
    logic [31:0] s1M;
    logic [33:0] s1U;
    // S2: a * b split into two 32x16 partial products
    logic [47:0] s2PLo;
    logic [47:0] s2PHi;
    logic [31:0] s2M;
    logic [33:0] s2U;
    // S3: full 64-bit product x
    logic [63:0] s3X;
    logic [31:0] s3M;
    logic [33:0] s3U;
    // S4: q1 * u split into two 33x17 partial products
    logic [49:0] s4P0;
    logic [49:0] s4P1;
    logic [33:0] s4XLo;
    logic [31:0] s4M;
    // S5: quotient estimate q
    logic [33:0] s5Q;
    logic [33:0] s5XLo;
    logic [31:0] s5M;
    // S6: low 34 bits of q * m
    logic [33:0] s6Qm;
    logic [33:0] s6XLo;
    logic [31:0] s6M;
    // S7: r = x - q*m (mod 2^34), in [0, 3m)
    logic [33:0] s7R;
    logic [31:0] s7M;
    // S8/S9: conditional subtractions
    logic [33:0] s8R;
    logic [31:0] s8M;
    logic [33:0] s9R;
    // S10: output register
    logic [31:0] s10R;
  } pipeT;

  pipeT        pipeQ;
  pipeT        pipeD;
  logic [32:0] q1;
  logic [66:0] prodQU;
  logic        unusedBits;

  // Next-state datapath for every stage; stages only ever read the previous stage's register.
  always_comb begin
    pipeD  = pipeQ;
    q1     = '0;
    prodQU = '0;

    pipeD.s1A = iData0;
    pipeD.s1B = iData1;
    pipeD.s1M = iMod;
    pipeD.s1U = iU[33:0];

    pipeD.s2PLo = {16'b0, pipeQ.s1A} * {32'b0, pipeQ.s1B[15:0]};
    pipeD.s2PHi = {16'b0, pipeQ.s1A} * {32'b0, pipeQ.s1B[31:16]};
    pipeD.s2M   = pipeQ.s1M;
    pipeD.s2U   = pipeQ.s1U;

    // Sum cannot overflow: it equals a*b < 2^64.
    pipeD.s3X = {16'b0, pipeQ.s2PLo} + {pipeQ.s2PHi, 16'b0};
    pipeD.s3M = pipeQ.s2M;
    pipeD.s3U = pipeQ.s2U;

    q1           = pipeQ.s3X[63:31];
    pipeD.s4P0   = {17'b0, q1} * {33'b0, pipeQ.s3U[16:0]};
    pipeD.s4P1   = {17'b0, q1} * {33'b0, pipeQ.s3U[33:17]};
    // r < 3m < 2^34, so only the low 34 bits of x are needed downstream.
    pipeD.s4XLo  = pipeQ.s3X[33:0];
    pipeD.s4M    = pipeQ.s3M;

    prodQU      = {17'b0, pipeQ.s4P0} + {pipeQ.s4P1, 17'b0};
    pipeD.s5Q   = prodQU[66:33];
    pipeD.s5XLo = pipeQ.s4XLo;
    pipeD.s5M   = pipeQ.s4M;

    pipeD.s6Qm  = pipeQ.s5Q * {2'b0, pipeQ.s5M};
    pipeD.s6XLo = pipeQ.s5XLo;
    pipeD.s6M   = pipeQ.s5M;

    pipeD.s7R = pipeQ.s6XLo - pipeQ.s6Qm;
    pipeD.s7M = pipeQ.s6M;

    pipeD.s8R = (pipeQ.s7R >= {2'b0, pipeQ.s7M}) ? pipeQ.s7R - {2'b0, pipeQ.s7M} : pipeQ.s7R;
    pipeD.s8M = pipeQ.s7M;

    pipeD.s9R = (pipeQ.s8R >= {2'b0, pipeQ.s8M}) ? pipeQ.s8R - {2'b0, pipeQ.s8M} : pipeQ.s8R;

    pipeD.s10R = pipeQ.s9R[31:0];
  end

  // Pipeline register: async reset, then sync clear, then enable; otherwise hold.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pipeQ <= '0;
    end else if (iClr) begin
      pipeQ <= '0;
    end else if (iEn) begin
      pipeQ <= pipeD;
    end
  end

  assign oData = pipeQ.s10R;

  // Bits that are intentionally dropped by the algorithm.
  assign unusedBits = ^{iU[63:34], prodQU[32:0], pipeQ.s9R[33:32]};

endmodule

// File: tb/tb_mod_mult_barrett_32b.sv
// Self-checking bench for mod_mult_barrett_32b. Expected results come from plain
// 64-bit a*b % m arithmetic (or spec constants) and are queued with the enabled-edge
// count at which they must appear on oData; every cycle checks oData.
module tb_mod_mult_barrett_32b;

  logic        iClk;
  logic        iRstN;
  logic        iEn;
  logic        iClr;
  logic [63:0] iU;
  logic [31:0] iData0;
  logic [31:0] iData1;
  logic [31:0] iMod;
  logic [31:0] oData;

  int checks   = 0;
  int failures = 0;
  int edgeCnt  = 0;
  logic [31:0] lastExp = '0;
  logic [31:0] expQ[$];
  int          dueQ[$];
  string       nameQ[$];

  localparam logic [31:0] MAll = 32'hFFFF_FFFF;
  localparam logic [63:0] UAll = 64'h1_0000_0001;

  mod_mult_barrett_32b dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iU     (iU),
    .iData0 (iData0),
    .iData1 (iData1),
    .iMod   (iMod),
    .oData  (oData)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] modelMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] m);
    logic [63:0] p;
    p = ({32'b0, a} * {32'b0, b}) % {32'b0, m};
    return p[31:0];
  endfunction

  // One clock: drive inputs, take the edge, then check oData against the scoreboard.
  task automatic cycle(input logic en, input logic clr, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] m, input logic [63:0] u,
                       input logic [31:0] expv, input string name);
    string n;
    iEn    = en;
    iClr   = clr;
    iData0 = a;
    iData1 = b;
    iMod   = m;
    iU     = u;
    @(posedge iClk);
    if (clr) begin
      expQ.delete();
      dueQ.delete();
      nameQ.delete();
      lastExp = '0;
    end else if (en) begin
      edgeCnt++;
      expQ.push_back(expv);
      dueQ.push_back(edgeCnt + 9);
      nameQ.push_back(name);
    end
    #1;
    n = "hold";
    if (dueQ.size() > 0 && dueQ[0] == edgeCnt) begin
      lastExp = expQ.pop_front();
      void'(dueQ.pop_front());
      n = nameQ.pop_front();
    end
    checks++;
    if (oData !== lastExp) begin
      failures++;
      $display("FAIL %s (edge %0d): oData=%h expected %h", n, edgeCnt, oData, lastExp);
    end
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iEn    = 1'b1;
      iClr   = 1'b0;
      iData0 = $urandom;
      iData1 = $urandom;
      iMod   = $urandom;
      iU     = {$urandom, $urandom};
      @(posedge iClk);
      #1;
      checks++;
      if (oData !== 32'd0) begin
        failures++;
        $display("FAIL reset_hold: oData=%h expected 00000000", oData);
      end
    end
    iRstN   = 1'b1;
    edgeCnt = 0;
    lastExp = '0;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 32'd0, 32'd0, MAll, UAll, 32'd0, "reset_zero");
  endtask

  task automatic test_directed();
    cycle(1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, MAll, UAll, 32'd1, "fffffffe_sq");
    cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd5, MAll, UAll, 32'd0, "m_times_5");
    cycle(1'b1, 1'b0, 32'd123456789, 32'd987654321, MAll, UAll, 32'd4256203929, "dec_pair");
    cycle(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 64'h2_0000_0000,
          32'd1, "m_2pow31");
    cycle(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 64'h1_FFFF_FFFC,
          32'd1, "m_2pow31_plus1");
    cycle(1'b1, 1'b0, 32'd7, 32'd9, MAll, UAll, 32'd63, "small");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      cycle(1'b1, 1'b0, a, b, MAll, UAll, modelMul(a, b, MAll), "b2b");
    end
  endtask

  // Random moduli above 2^31; m is never a power of two so (2^64-1)/m == floor(2^64/m).
  // Junk in iU[63:34] must be ignored.
  task automatic test_random_mod();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic [63:0] u;
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      m = $urandom | 32'h8000_0001;
      u = 64'hFFFF_FFFF_FFFF_FFFF / {32'b0, m};
      u[63:34] = {$urandom, $urandom} >> 2;
      cycle(1'b1, 1'b0, a, b, m, u, modelMul(a, b, m), "rand_mod");
    end
  endtask

  task automatic test_stall();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 14; i++) begin
      if (i >= 5 && i < 8) begin
        cycle(1'b0, 1'b0, $urandom, $urandom, MAll, UAll, 32'd0, "stall");
      end else begin
        a = $urandom;
        b = $urandom;
        cycle(1'b1, 1'b0, a, b, MAll, UAll, modelMul(a, b, MAll), "stall_stream");
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      cycle(1'b1, 1'b0, a, b, MAll, UAll, modelMul(a, b, MAll), "pre_clear");
    end
    cycle(1'b1, 1'b1, $urandom, $urandom, MAll, UAll, 32'd0, "clear");
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 32'd0, 32'd0, MAll, UAll, 32'd0, "post_clear");
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = $urandom;
      cycle(1'b1, 1'b0, a, b, MAll, UAll, modelMul(a, b, MAll), "after_clear");
    end
    // Stalled clear must also zero everything.
    cycle(1'b0, 1'b1, 32'd3, 32'd3, MAll, UAll, 32'd0, "clear_stalled");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'd0, 32'd0, MAll, UAll, 32'd0, "flush");
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    for (int i = 0; i < 12; i++) begin
      a = $urandom | 32'h1;
      cycle(1'b1, 1'b0, a, 32'd1, MAll, UAll, modelMul(a, 32'd1, MAll), "pre_async");
    end
    iRstN = 1'b0;
    #1;
    checks++;
    if (oData !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: oData=%h expected 00000000", oData);
    end
    #2;
    iRstN = 1'b1;
  endtask

  initial begin
    iRstN  = 1'b0;
    iEn    = 1'b0;
    iClr   = 1'b0;
    iU     = '0;
    iData0 = '0;
    iData1 = '0;
    iMod   = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random_mod();
    test_stall();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
